// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the hxd32 load/store unit.
// Op codes outside the enum (011, 110, 111) decode as word accesses.
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_LB  = 3'b000,
      LSU_LH  = 3'b001,
      LSU_LW  = 3'b010,
      LSU_LBU = 3'b100,
      LSU_LHU = 3'b101
   } lsu_op_t;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_BUS,
      LSU_RESP
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } lsu_size_t;

   // Bit 2 only selects sign, so the low two bits alone give the access size.
   function automatic lsu_size_t op_size(input logic [2:0] op);
      case (op[1:0])
         2'b00:   return SZ_BYTE;
         2'b01:   return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
      case (op_size(op))
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         default: return |off;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] off);
      case (op_size(op))
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lane(input logic [2:0] op, input logic [31:0] wdata);
      case (op_size(op))
         SZ_BYTE: return {4{wdata[7:0]}};
         SZ_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Aligns a bus read word to the addressed byte and sign/zero-extends it.
// Purely combinational so a cache-refill path can share it.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  op_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {off_i, 3'b000};

   // NOTE: data_o gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      data_o = shifted;
      case (op_size(op_i))
         SZ_BYTE: data_o = op_i[2] ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: data_o = op_i[2] ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// hxd32 load/store unit: one data-bus transaction per accepted request,
// with misalignment detection and an optional ack timeout.
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [2:0]      req_op_i,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   output logic            rsp_valid_o,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_misalign_o,
   output logic            rsp_buserr_o,
   output logic            dbus_req_o,
   output logic            dbus_we_o,
   output logic [XLEN-1:0] dbus_addr_o,
   output logic [3:0]      dbus_be_o,
   output logic [XLEN-1:0] dbus_wdata_o,
   input  logic            dbus_ack_i,
   input  logic [XLEN-1:0] dbus_rdata_i
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   lsu_state_t       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic             we_q, we_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [1:0]       off_q, off_d;
   logic [3:0]       be_q, be_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [XLEN-1:0]  rdata_q, rdata_d;
   logic             misalign_q, misalign_d;
   logic             buserr_q, buserr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  ext_data;

   lsu_load_ext u_load_ext (
      .rdata_i (dbus_rdata_i),
      .off_i   (off_q),
      .op_i    (op_q),
      .data_o  (ext_data)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      we_d       = we_q;
      addr_d     = addr_q;
      off_d      = off_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = misalign_q;
      buserr_d   = buserr_q;
      cnt_d      = cnt_q;

      case (state_q)
         LSU_IDLE: begin
            if (req_valid_i) begin
               op_d       = req_op_i;
               we_d       = req_we_i;
               addr_d     = {req_addr_i[XLEN-1:2], 2'b00};
               off_d      = req_addr_i[1:0];
               be_d       = byte_en(req_op_i, req_addr_i[1:0]);
               wdata_d    = store_lane(req_op_i, req_wdata_i);
               rdata_d    = '0;
               buserr_d   = 1'b0;
               cnt_d      = '0;
               misalign_d = is_misaligned(req_op_i, req_addr_i[1:0]);
               state_d    = misalign_d ? LSU_RESP : LSU_BUS;
            end
         end
         LSU_BUS: begin
            // Ack is tested first so it wins over a timeout on the same cycle.
            if (dbus_ack_i) begin
               rdata_d = we_q ? '0 : ext_data;
               state_d = LSU_RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               buserr_d = 1'b1;
               state_d  = LSU_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LSU_RESP: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   // NOTE: only the state register is reset; datapath registers are reloaded on
   // every accept and every output is gated by state, so stale contents never leak.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= LSU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk_i) begin
      op_q       <= op_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
      cnt_q      <= cnt_d;
   end

   assign req_ready_o    = (state_q == LSU_IDLE);

   assign dbus_req_o     = (state_q == LSU_BUS);
   assign dbus_we_o      = dbus_req_o & we_q;
   assign dbus_addr_o    = dbus_req_o ? addr_q  : '0;
   assign dbus_be_o      = dbus_req_o ? be_q    : 4'b0000;
   assign dbus_wdata_o   = dbus_req_o ? wdata_q : '0;

   assign rsp_valid_o    = (state_q == LSU_RESP);
   assign rsp_rdata_o    = rsp_valid_o ? rdata_q : '0;
   assign rsp_misalign_o = rsp_valid_o & misalign_q;
   assign rsp_buserr_o   = rsp_valid_o & buserr_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected responses are queued at issue time and
// a negedge monitor pops and compares them whenever rsp_valid_o is seen.
module tb_lsu;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [2:0]  req_op_i = 3'b000;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_misalign_o;
   logic        rsp_buserr_o;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_ack_i = 1'b0;
   logic [31:0] dbus_rdata_i = '0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        misalign;
      logic        buserr;
   } rsp_t;

   rsp_t exp_q[$];

   lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_op_i       (req_op_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_misalign_o (rsp_misalign_o),
      .rsp_buserr_o   (rsp_buserr_o),
      .dbus_req_o     (dbus_req_o),
      .dbus_we_o      (dbus_we_o),
      .dbus_addr_o    (dbus_addr_o),
      .dbus_be_o      (dbus_be_o),
      .dbus_wdata_o   (dbus_wdata_o),
      .dbus_ack_i     (dbus_ack_i),
      .dbus_rdata_i   (dbus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: any response pulse must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (!rst_i && rsp_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata_o, e.rdata);
            check("rsp_misalign", {31'd0, rsp_misalign_o}, {31'd0, e.misalign});
            check("rsp_buserr", {31'd0, rsp_buserr_o}, {31'd0, e.buserr});
         end
      end
   end

   task automatic expect_rsp(input logic [31:0] rdata, input logic mis, input logic berr);
      rsp_t e;
      e.rdata    = rdata;
      e.misalign = mis;
      e.buserr   = berr;
      exp_q.push_back(e);
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge.
   task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata);
      int n = 0;
      while (!req_ready_o && n < 50) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (!req_ready_o) check("ready_timeout", 32'd0, 32'd1);
      req_we_i    = we;
      req_op_i    = op;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
   endtask

   // Entered #1 after accept; checks the bus fields, acks after 'waits' cycles.
   task automatic bus_ack(input string name, input int waits, input logic [31:0] rdata,
                          input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
      check({name, "_req"}, {31'd0, dbus_req_o}, 32'd1);
      check({name, "_we"}, {31'd0, dbus_we_o}, {31'd0, we});
      check({name, "_addr"}, dbus_addr_o, addr);
      check({name, "_be"}, {28'd0, dbus_be_o}, {28'd0, be});
      if (we) check({name, "_wdata"}, dbus_wdata_o, wdata);
      repeat (waits) begin
         @(posedge clk_i); #1;
      end
      check({name, "_req_held"}, {31'd0, dbus_req_o}, 32'd1);
      dbus_ack_i   = 1'b1;
      dbus_rdata_i = rdata;
      @(posedge clk_i); #1;
      dbus_ack_i   = 1'b0;
      dbus_rdata_i = 32'h0;
      check({name, "_rsp_lat"}, {31'd0, rsp_valid_o}, 32'd1);
      check({name, "_req_drop"}, {31'd0, dbus_req_o}, 32'd0);
   endtask

   task automatic misaligned(input string name, input logic we, input logic [2:0] op,
                             input logic [31:0] addr);
      expect_rsp(32'h0, 1'b1, 1'b0);
      issue(we, op, addr, 32'hFFFF_FFFF);
      check({name, "_no_req"}, {31'd0, dbus_req_o}, 32'd0);
      check({name, "_rsp_lat"}, {31'd0, rsp_valid_o}, 32'd1);
      @(posedge clk_i); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ready", {31'd0, req_ready_o}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      check("rst_dbus_req", {31'd0, dbus_req_o}, 32'd0);
      check("rst_dbus_addr", dbus_addr_o, 32'h0);
      check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // LB 0x103: lane 3 of 0x80AABBCC = 0x80, sign-extended
      expect_rsp(32'hFFFF_FF80, 1'b0, 1'b0);
      issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
      check("lb_ready_low", {31'd0, req_ready_o}, 32'd0);
      bus_ack("lb", 2, 32'h80AA_BBCC, 1'b0, 32'h0000_0100, 4'b1000, 32'h0);
      @(posedge clk_i); #1;

      // SH 0x202: half replicated, upper lanes enabled, rdata forced 0
      expect_rsp(32'h0, 1'b0, 1'b0);
      issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
      bus_ack("sh", 0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
      @(posedge clk_i); #1;

      misaligned("lw_mis", 1'b0, 3'b010, 32'h0000_0101);
      misaligned("lh_mis", 1'b0, 3'b001, 32'h0000_0003);
      misaligned("sh_mis", 1'b1, 3'b001, 32'h0000_0201);
      misaligned("sw_mis", 1'b1, 3'b010, 32'h0000_0302);

      // LHU 0x002: upper half of 0xF00D1234 zero-extended
      expect_rsp(32'h0000_F00D, 1'b0, 1'b0);
      issue(1'b0, 3'b101, 32'h0000_0002, 32'h0);
      bus_ack("lhu", 1, 32'hF00D_1234, 1'b0, 32'h0000_0000, 4'b1100, 32'h0);
      @(posedge clk_i); #1;

      // LH 0x002: upper half 0x8001 sign-extended
      expect_rsp(32'hFFFF_8001, 1'b0, 1'b0);
      issue(1'b0, 3'b001, 32'h0000_0002, 32'h0);
      bus_ack("lh", 0, 32'h8001_7FFF, 1'b0, 32'h0000_0000, 4'b1100, 32'h0);
      @(posedge clk_i); #1;

      // LBU 0x001: lane 1 of 0x0000A500 = 0xA5, zero-extended
      expect_rsp(32'h0000_00A5, 1'b0, 1'b0);
      issue(1'b0, 3'b100, 32'h0000_0001, 32'h0);
      bus_ack("lbu", 0, 32'h0000_A500, 1'b0, 32'h0000_0000, 4'b0010, 32'h0);
      @(posedge clk_i); #1;

      // SB 0x001: byte replicated into every lane
      expect_rsp(32'h0, 1'b0, 1'b0);
      issue(1'b1, 3'b000, 32'h0000_0001, 32'h7777_7755);
      bus_ack("sb", 0, 32'h0, 1'b1, 32'h0000_0000, 4'b0010, 32'h5555_5555);
      @(posedge clk_i); #1;

      // SW 0x010: data unchanged, all lanes
      expect_rsp(32'h0, 1'b0, 1'b0);
      issue(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D);
      bus_ack("sw", 1, 32'h0, 1'b1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D);
      @(posedge clk_i); #1;

      // Reserved op 011 behaves as LW
      expect_rsp(32'h89AB_CDEF, 1'b0, 1'b0);
      issue(1'b0, 3'b011, 32'h0000_0104, 32'h0);
      bus_ack("rsvd", 0, 32'h89AB_CDEF, 1'b0, 32'h0000_0104, 4'b1111, 32'h0);
      @(posedge clk_i); #1;

      // Timeout: request held TO cycles, then bus error
      expect_rsp(32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
      for (int i = 0; i < TO; i++) begin
         check("to_req_held", {31'd0, dbus_req_o}, 32'd1);
         @(posedge clk_i); #1;
      end
      check("to_req_drop", {31'd0, dbus_req_o}, 32'd0);
      check("to_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      @(posedge clk_i); #1;

      // Ack on the expiring cycle wins over the timeout
      expect_rsp(32'h1357_9BDF, 1'b0, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_0304, 32'h0);
      bus_ack("to_edge", TO - 1, 32'h1357_9BDF, 1'b0, 32'h0000_0304, 4'b1111, 32'h0);
      @(posedge clk_i); #1;

      // Reset in BUS aborts with no response
      issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
      check("abort_in_bus", {31'd0, dbus_req_o}, 32'd1);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check("abort_req_drop", {31'd0, dbus_req_o}, 32'd0);
      check("abort_ready", {31'd0, req_ready_o}, 32'd1);
      check("abort_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      rst_i = 1'b0;

      // Back-to-back request after the abort
      expect_rsp(32'h0000_0042, 1'b0, 1'b0);
      issue(1'b0, 3'b100, 32'h0000_0404, 32'h0);
      bus_ack("post_rst", 0, 32'hFFFF_FF42, 1'b0, 32'h0000_0404, 4'b0001, 32'h0);
      @(posedge clk_i); #1;
      repeat (3) @(posedge clk_i);
      #1;

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
